writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Writeback arbiter that merges the two result sources of the core into the single write port of the 32x32 register file. Single-cycle ALU results take priority; load data returning from the data cache, possibly late after a miss, is buffered in a small in-order queue and drained into idle write slots. A starvation counter bounds load latency. Outputs drive the register file's A3/WD/WE directly.

## Interface
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register index width
- DEPTH, 4, load queue entries (power of two, >= 2)
- STARVE_LIMIT, 8, consecutive blocked cycles before a load is forced out (>= 1)

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous reset, active-low
- ALU_VALID  in  1  ALU result present
- ALU_RD  in  ADDR_WIDTH  ALU destination register
- ALU_RESULT  in  DATA_WIDTH  ALU result
- ALU_READY  out  1  ALU result accepted this cycle when high with ALU_VALID
- LD_VALID  in  1  cache load data present
- LD_RD  in  ADDR_WIDTH  load destination register
- LD_DATA  in  DATA_WIDTH  load data
- LD_READY  out  1  queue can accept; load accepted on LD_VALID && LD_READY
- PENDING  out  2^ADDR_WIDTH  bit r high while a queued load targets register r
- A3  out  ADDR_WIDTH  register file write address (registered)
- WD  out  DATA_WIDTH  register file write data (registered)
- WE  out  1  register file write enable (registered)

## Operation
- Load queue: FIFO of {rd, data}, DEPTH entries, wrap-around read/write pointers plus count of width log2(DEPTH)+1.
- LD_READY = (count < DEPTH), combinational from state only; never depends on LD_VALID.
- Accepted load with LD_RD == 0 is consumed and discarded (not queued).
- Write slot per cycle, decided combinationally, registered into A3/WD/WE at the edge:
  - force = (count != 0) && (starve_cnt == STARVE_LIMIT).
  - ALU_READY = !force.
  - If ALU_VALID && ALU_READY && ALU_RD != 0: slot = ALU.
  - Else if count != 0: slot = queue head; head popped.
  - Else: WE <= 0 next cycle; A3/WD hold previous values.
  - ALU result with ALU_RD == 0 is accepted (if ALU_READY) but produces no write and does not consume the slot.
- starve_cnt (saturating at STARVE_LIMIT): cleared when queue empty or a load pops; incremented when count != 0 and ALU takes the slot.
- Simultaneous push and pop: both occur; count unchanged. Push into empty queue is not bypassed; it is visible to pop next cycle.
- Full queue with ALU taking slot: LD_READY = 0; loads back-pressured.
- PENDING: OR over valid queue entries of one-hot(rd), combinational from state. Upstream hazard logic stalls any ALU instruction writing a PENDING register; ordering is then guaranteed in-order per source.
- Reset (asynchronous, any time, including mid-drain): queue emptied, pointers/count/starve_cnt = 0, WE = 0, A3 = 0, WD = 0; hence LD_READY = 1, ALU_READY = 1, PENDING = 0. Queued loads are discarded.

## Timing
- ALU path: accepted at edge N -> WE/A3/WD valid during cycle N+1 -> register written at edge N+2.
- Load path: accepted at edge N -> earliest pop at edge N+1 -> WE during cycle N+2 -> written at edge N+3.
- Forced slot: ALU_READY low for exactly one cycle per force; starve_cnt cleared on that edge.
- Max load wait at head with continuous ALU traffic: STARVE_LIMIT + 1 cycles.
- PENDING bit clears on the edge the last load to that rd pops (same edge WE rises for it).
- Throughput: one register write per cycle maximum.

## Test plan
- Reset: hold RST = 0 two cycles with ALU_VALID = 1 -> WE = 0, A3 = 0, WD = 0, LD_READY = 1, PENDING = 0; release -> ALU rd = 5, data 0x0000_0005 gives WE = 1, A3 = 5 one cycle later.
- Idle drain: push loads rd 1..4 data 0x11..0x44 back-to-back, no ALU -> WE high four consecutive cycles, A3 = 1,2,3,4 in order, first write two cycles after first accept; PENDING bits 1..4 set then cleared in order.
- Full/back-pressure: ALU writes every cycle rd 7, push 5 loads -> LD_READY falls after 4th accept, 5th held until a pop; no load lost or duplicated.
- Starvation: STARVE_LIMIT = 8, ALU_VALID continuous rd 9, one queued load rd 3 data 0xDEAD_BEEF -> after 8 ALU writes ALU_READY = 0 for one cycle, WE writes rd 3 = 0xDEAD_BEEF, ALU resumes with held result.
- x0 handling: ALU_RD = 0 data 0xFFFF_FFFF while load rd 2 queued -> load written that cycle; load with LD_RD = 0 accepted, never written, PENDING[0] stays 0.
- Reset mid-operation: 3 loads queued, assert RST -> WE drops immediately, count 0, PENDING = 0; after release no stale writes appear.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: ALU results own the register-file write port, late load data
// waits in an in-order queue and drains into idle slots, with a starvation bound.
module writeback_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ALU_VALID,
  input  logic [ADDR_WIDTH-1:0]      ALU_RD,
  input  logic [DATA_WIDTH-1:0]      ALU_RESULT,
  output logic                       ALU_READY,
  input  logic                       LD_VALID,
  input  logic [ADDR_WIDTH-1:0]      LD_RD,
  input  logic [DATA_WIDTH-1:0]      LD_DATA,
  output logic                       LD_READY,
  output logic [(1<<ADDR_WIDTH)-1:0] PENDING,
  output logic [ADDR_WIDTH-1:0]      A3,
  output logic [DATA_WIDTH-1:0]      WD,
  output logic                       WE
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam int NREG  = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] rd_mem_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ST_W-1:0]       starve_q, starve_d;
  logic [ADDR_WIDTH-1:0] a3_q, a3_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic                  we_q, we_d;

  logic                  force_s;
  logic                  alu_take_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  not_empty_s;
  logic [DEPTH-1:0]      entry_valid_s;
  logic [NREG-1:0]       pending_s;

  assign not_empty_s = (count_q != {CNT_W{1'b0}});
  assign force_s     = not_empty_s && (starve_q == ST_W'(STARVE_LIMIT));
  assign ALU_READY   = !force_s;
  assign LD_READY    = (count_q < CNT_W'(DEPTH));
  assign alu_take_s  = ALU_VALID && !force_s && (ALU_RD != {ADDR_WIDTH{1'b0}});
  assign pop_s       = !alu_take_s && not_empty_s;
  // Loads to x0 complete the handshake but never occupy a queue entry.
  assign push_s      = LD_VALID && LD_READY && (LD_RD != {ADDR_WIDTH{1'b0}});

  // A physical entry is live when its distance from the read pointer is below count.
  for (genvar j = 0; j < DEPTH; j++) begin : g_valid
    assign entry_valid_s[j] = ({1'b0, PTR_W'(j) - rd_ptr_q} < count_q);
  end

  // Pending-write mask: OR of one-hot destination over live entries.
  always_comb begin
    pending_s = {NREG{1'b0}};
    for (int j = 0; j < DEPTH; j++) begin
      pending_s = pending_s | ({NREG{entry_valid_s[j]}} & (NREG'(1) << rd_mem_q[j]));
    end
  end
  assign PENDING = pending_s;

  // Next-state for pointers, occupancy, starvation counter and the write slot.
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);

    if (!not_empty_s || pop_s) begin
      starve_d = {ST_W{1'b0}};
    end else if (alu_take_s && (starve_q != ST_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + ST_W'(1);
    end else begin
      starve_d = starve_q;
    end

    if (alu_take_s) begin
      we_d = 1'b1;
      a3_d = ALU_RD;
      wd_d = ALU_RESULT;
    end else if (pop_s) begin
      we_d = 1'b1;
      a3_d = rd_mem_q[rd_ptr_q];
      wd_d = data_mem_q[rd_ptr_q];
    end else begin
      we_d = 1'b0;
      a3_d = a3_q;
      wd_d = wd_q;
    end
  end

  // State and registered register-file port.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      starve_q <= {ST_W{1'b0}};
      a3_q     <= {ADDR_WIDTH{1'b0}};
      wd_q     <= {DATA_WIDTH{1'b0}};
      we_q     <= 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        rd_mem_q[j]   <= {ADDR_WIDTH{1'b0}};
        data_mem_q[j] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      a3_q     <= a3_d;
      wd_q     <= wd_d;
      we_q     <= we_d;
      if (push_s) begin
        rd_mem_q[wr_ptr_q]   <= LD_RD;
        data_mem_q[wr_ptr_q] <= LD_DATA;
      end else begin
        rd_mem_q[wr_ptr_q]   <= rd_mem_q[wr_ptr_q];
        data_mem_q[wr_ptr_q] <= data_mem_q[wr_ptr_q];
      end
    end
  end

  assign A3 = a3_q;
  assign WD = wd_q;
  assign WE = we_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter against a queue-based model.
module tb_writeback_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          ALU_VALID = 1'b0;
  logic [AW-1:0] ALU_RD = '0;
  logic [DW-1:0] ALU_RESULT = '0;
  logic          ALU_READY;
  logic          LD_VALID = 1'b0;
  logic [AW-1:0] LD_RD = '0;
  logic [DW-1:0] LD_DATA = '0;
  logic          LD_READY;
  logic [31:0]   PENDING;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD;
  logic          WE;

  writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST(RST),
    .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_RESULT(ALU_RESULT), .ALU_READY(ALU_READY),
    .LD_VALID(LD_VALID), .LD_RD(LD_RD), .LD_DATA(LD_DATA), .LD_READY(LD_READY),
    .PENDING(PENDING), .A3(A3), .WD(WD), .WE(WE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  int            waited;
  logic          exp_we;
  logic [AW-1:0] exp_a3;
  logic [DW-1:0] exp_wd;
  int            errors = 0;
  int            checks = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p;
    p = 32'd0;
    foreach (mq[i]) p[mq[i].rd] = 1'b1;
    return p;
  endfunction

  task automatic model_clear();
    mq.delete();
    waited = 0;
    exp_we = 1'b0;
    exp_a3 = '0;
    exp_wd = '0;
  endtask

  // Called at a negedge; returns at the next negedge after checking the written slot.
  task automatic step(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] adata,
                      input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldata,
                      output logic alu_acc, output logic ld_acc);
    logic forced, alu_wins, ld_room, head_goes;
    ALU_VALID = av; ALU_RD = ard; ALU_RESULT = adata;
    LD_VALID = lv; LD_RD = lrd; LD_DATA = ldata;
    #1;
    ld_room   = (mq.size() < DEPTH);
    forced    = (mq.size() != 0) && (waited >= LIMIT);
    alu_wins  = av && !forced && (ard != 5'd0);
    head_goes = !alu_wins && (mq.size() != 0);
    check_val("ld_ready", {63'd0, LD_READY}, {63'd0, ld_room});
    check_val("alu_ready", {63'd0, ALU_READY}, {63'd0, !forced});
    check_val("pending", {32'd0, PENDING}, {32'd0, model_pending()});
    alu_acc = av && !forced;
    ld_acc  = lv && ld_room;
    @(posedge CLK);
    if (mq.size() == 0 || head_goes) waited = 0;
    else if (alu_wins) waited = waited + 1;
    if (alu_wins) begin
      exp_we = 1'b1; exp_a3 = ard; exp_wd = adata;
    end else if (head_goes) begin
      ent_t h;
      h = mq.pop_front();
      exp_we = 1'b1; exp_a3 = h.rd; exp_wd = h.data;
    end else begin
      exp_we = 1'b0;
    end
    if (ld_acc && lrd != 5'd0) mq.push_back('{rd: lrd, data: ldata});
    @(negedge CLK);
    check_val("we", {63'd0, WE}, {63'd0, exp_we});
    check_val("a3", {59'd0, A3}, {59'd0, exp_a3});
    check_val("wd", {32'd0, WD}, {32'd0, exp_wd});
  endtask

  // Asserts reset at a negedge, holds two cycles with ALU traffic, releases at a negedge.
  task automatic do_reset();
    RST = 1'b0;
    ALU_VALID = 1'b1; ALU_RD = 5'd6; ALU_RESULT = 32'h0000_0066;
    LD_VALID = 1'b0;
    #1;
    model_clear();
    for (int c = 0; c < 2; c++) begin
      check_val("rst_we", {63'd0, WE}, 64'd0);
      check_val("rst_a3", {59'd0, A3}, 64'd0);
      check_val("rst_wd", {32'd0, WD}, 64'd0);
      check_val("rst_ld_ready", {63'd0, LD_READY}, 64'd1);
      check_val("rst_alu_ready", {63'd0, ALU_READY}, 64'd1);
      check_val("rst_pending", {32'd0, PENDING}, 64'd0);
      @(negedge CLK);
    end
    RST = 1'b1;
  endtask

  initial begin
    logic aa, la;
    int n, idx;
    logic          r_av, r_lv;
    logic [AW-1:0] r_ard, r_lrd;
    logic [DW-1:0] r_adata, r_ldata;

    model_clear();
    @(negedge CLK);
    do_reset();
    step(1'b1, 5'd5, 32'h0000_0005, 1'b0, 5'd0, 32'd0, aa, la);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, aa, la);

    // Idle drain of four back-to-back loads.
    for (int k = 1; k <= 4; k++)
      step(1'b0, 5'd0, 32'd0, 1'b1, AW'(k), 32'(k * 32'h11), aa, la);
    for (int k = 0; k < 4; k++)
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, aa, la);

    // Back-pressure: ALU to r7 every cycle while five loads are offered.
    idx = 0; n = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 5'd7, 32'h0700_0000 + 32'(n), idx < 5, AW'(10 + idx), 32'hA000_0000 + 32'(idx), aa, la);
      if (aa) n++;
      if (la && idx < 5) idx++;
    end
    check_val("all_loads_accepted", 64'(idx), 64'd5);
    for (int c = 0; c < 6; c++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, aa, la);

    // Starvation: single load to r3 under continuous ALU traffic to r9.
    n = 0; idx = 0;
    for (int c = 0; c < 14; c++) begin
      step(1'b1, 5'd9, 32'h0900_0000 + 32'(n), idx == 0, 5'd3, 32'hDEAD_BEEF, aa, la);
      if (aa) n++;
      if (la) idx = 1;
    end

    // x0 handling: ALU to x0 yields the slot; load to x0 is swallowed.
    step(1'b1, 5'd9, 32'h0000_0009, 1'b1, 5'd2, 32'h0000_0222, aa, la);
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'h0000_0BAD, aa, la);
    for (int c = 0; c < 3; c++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, aa, la);

    // Reset while three loads sit in the queue.
    for (int k = 0; k < 3; k++)
      step(1'b1, 5'd7, 32'h0000_0700 + 32'(k), 1'b1, AW'(20 + k), 32'h0000_2000 + 32'(k), aa, la);
    do_reset();
    for (int c = 0; c < 4; c++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, aa, la);

    // Randomized traffic with hold-until-accepted sources.
    r_av = 1'b0; r_lv = 1'b0; r_ard = '0; r_lrd = '0; r_adata = '0; r_ldata = '0;
    for (int c = 0; c < 800; c++) begin
      if (!r_av) begin
        r_av = ($urandom_range(0, 99) < 70);
        r_ard = ($urandom_range(0, 9) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
        r_adata = $urandom;
      end
      if (!r_lv) begin
        r_lv = ($urandom_range(0, 99) < 45);
        r_lrd = ($urandom_range(0, 9) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
        r_ldata = $urandom;
      end
      step(r_av, r_ard, r_adata, r_lv, r_lrd, r_ldata, aa, la);
      if (aa) r_av = 1'b0;
      if (la) r_lv = 1'b0;
      if (c == 400) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
